key_filter: RTL
===============

KEY_FILTER -- requirements
Module: key_filter

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 50000: cycles the synchronized key must be stable before a state change is accepted; legal range 2..2^CNT_W-1.
REQ-002 Parameter CNT_W, default 16: width of the debounce counter.
REQ-003 Parameter LONG_CYC, default 24'd5000000: cycles held in PRESSED before a long-press event; used only when KEY_LONGPRESS_EN is defined.
REQ-004 Port clock, input, 1: single clock; all flops on posedge clock.
REQ-005 Port rstn, input, 1: reset, asynchronous, active-low.
REQ-006 Port key_in, input, 1: raw asynchronous key; 0 = pressed, 1 = released.
REQ-007 Port key_state, output, 1: debounced level; 1 = pressed.
REQ-008 Port press_pulse, output, 1: one-cycle pulse on an accepted press.
REQ-009 Port release_pulse, output, 1: one-cycle pulse on an accepted release.
REQ-010 Port press_count, output, 8: count of accepted presses.
REQ-011 Port long_pulse, output, 1: one-cycle long-press pulse.

Function
REQ-012 key_in shall pass through a 2-flop synchronizer, key_s, before any use.
REQ-013 The FSM shall have the states IDLE, PRESS_CHK, PRESSED and RELEASE_CHK, plus a debounce counter cnt of CNT_W bits.
- IDLE: if key_s = 0, go to PRESS_CHK and set cnt = 0.
- PRESS_CHK: if key_s = 1, return to IDLE and set cnt = 0.
- PRESS_CHK: else if cnt = DEBOUNCE_CYC-1, go to PRESSED.
- PRESS_CHK: otherwise increment cnt.
- PRESSED: if key_s = 1, go to RELEASE_CHK and set cnt = 0.
- RELEASE_CHK: this state mirrors PRESS_CHK, with the opposite key level.
REQ-014 A bounce during a CHK state shall return the FSM to the prior stable state and clear cnt; no pulse is produced.
REQ-015 press_pulse shall be registered and high for exactly the one cycle after the PRESS_CHK->PRESSED edge.
REQ-016 release_pulse shall be registered and high for exactly the one cycle after the RELEASE_CHK->IDLE edge.
REQ-017 Latency: key_in is first sampled low at edge e0 and then held low. press_pulse shall be high after edge e0+DEBOUNCE_CYC+2. The same rule applies to release_pulse.
REQ-018 key_state shall be 1 in PRESSED and in RELEASE_CHK, and 0 otherwise; it changes on the same edge as the corresponding pulse.
REQ-019 press_count shall increment on the edge that raises press_pulse and shall wrap from 255 to 0.
REQ-020 press_pulse and release_pulse shall never be high in the same cycle.
REQ-021 The pulses shall never be high in two consecutive cycles.

Reset
REQ-022 While rstn = 0 the block shall hold:
- synchronizer flops = 1;
- state = IDLE;
- cnt = 0, plus the hold counter when KEY_LONGPRESS_EN is defined;
- key_state = press_pulse = release_pulse = long_pulse = 0;
- press_count = 0.
REQ-023 Reset asserted mid-debounce or mid-hold shall abort the operation without emitting any pulse.
REQ-024 After rstn rises, a key already held low shall be re-debounced from IDLE.

Configuration
REQ-025 The macro KEY_LONGPRESS_EN controls long-press detection.
REQ-026 With KEY_LONGPRESS_EN defined:
- a 24-bit hold counter clears on entry to PRESSED;
- it increments each cycle in PRESSED and saturates at LONG_CYC;
- long_pulse is high for one cycle when the hold counter reaches LONG_CYC-1;
- at most one long_pulse per press;
- leaving PRESSED before LONG_CYC cycles produces no long_pulse.
REQ-027 Without KEY_LONGPRESS_EN, long_pulse shall be tied to 0, no hold counter shall be built, and the port list is unchanged.

Verification (DEBOUNCE_CYC=4, LONG_CYC=10)
REQ-028 Reset check: rstn = 0 with key_in = 0 -> all outputs 0. Then release rstn -> press_pulse after 6 edges.
REQ-029 Clean press: key_in 1->0 held -> press_pulse high exactly 6 edges after the first low sample; key_state = 1; press_count = 1.
REQ-030 Bounce: key_in low for 3 cycles, high for 1, then low held -> no pulse from the first burst; press_pulse 6 edges after the final falling sample.
REQ-031 Wrap: 256 clean press/release pairs -> press_count = 0 and 256 release_pulses.
REQ-032 Long press, macro defined: hold 20 cycles after press_pulse -> exactly one long_pulse, 9 edges after press_pulse. Hold 5 cycles -> none.
REQ-033 Long press, macro undefined: same stimulus -> long_pulse constantly 0. Mid-debounce rstn pulse -> no pulses and state back to IDLE.

Source files
------------

// File: rtl/key_filter.sv
// Debounced key with press/release pulses, an 8-bit press counter and an optional long-press pulse (KEY_LONGPRESS_EN).
// Latency: a pulse appears DEBOUNCE_CYC+2 edges after the first stable sample; no backpressure, the outputs are free-running.
module key_filter #(
    parameter int          DEBOUNCE_CYC = 50000,
    parameter int          CNT_W        = 16,
    parameter logic [23:0] LONG_CYC     = 24'd5000000
) (
    input  logic       clock,
    input  logic       rstn,
    input  logic       key_in,
    output logic       key_state,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic [7:0] press_count,
    output logic       long_pulse
);

    typedef enum logic [1:0] {IDLE, PRESS_CHK, PRESSED, RELEASE_CHK} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1;
    logic             key_s;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             press_nxt;
    logic             release_nxt;

    // Flops reset to the released level so reset never looks like a press.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            sync1 <= 1'b1;
            key_s <= 1'b1;
        end else begin
            sync1 <= key_in;
            key_s <= sync1;
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (!key_s) begin
                    state_nxt = PRESS_CHK;
                    cnt_nxt   = '0;
                end
            end
            PRESS_CHK: begin
                if (key_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (key_s) begin
                    state_nxt = RELEASE_CHK;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_CHK: begin
                if (!key_s) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Registered from next-state so key_state moves on the same edge as the pulses.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            key_state     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            key_state     <= (state_nxt == PRESSED) || (state_nxt == RELEASE_CHK);
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            if (press_nxt) begin
                press_count <= press_count + 8'd1;
            end
        end
    end

`ifdef KEY_LONGPRESS_EN
    logic [23:0] hold;

    // Hold time restarts only on a fresh press; a release bounce keeps the count, so one pulse per press.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            hold       <= 24'd0;
            long_pulse <= 1'b0;
        end else begin
            long_pulse <= 1'b0;
            if (state == PRESS_CHK && state_nxt == PRESSED) begin
                hold <= 24'd0;
            end else if (state == PRESSED && state_nxt == PRESSED && hold != LONG_CYC) begin
                hold <= hold + 24'd1;
                if (hold == LONG_CYC - 24'd2) begin
                    long_pulse <= 1'b1;
                end
            end
        end
    end
`else
    assign long_pulse = 1'b0 & (|LONG_CYC);
`endif

endmodule
